vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator: horizontal and vertical counters, sync pulses,

---
 rtl/vga_timing_gen_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 48 ++++
 rtl/vga_timing_gen.sv | 136 +++++++++++++
 tb/tb_vga_timing_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared types, mode presets and helpers for the VGA raster timing generator.
package vga_timing_gen_pkg;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_mode_t;

   localparam axis_mode_t VGA_800X600_72_H = '{active: 800, fp: 56, sync: 120, bp: 64};
   localparam axis_mode_t VGA_800X600_72_V = '{active: 600, fp: 37, sync: 6, bp: 23};
   localparam axis_mode_t VGA_640X480_60_HALF_H = '{active: 640, fp: 16, sync: 96, bp: 48};
   localparam axis_mode_t VGA_640X480_60_HALF_V = '{active: 480, fp: 10, sync: 2, bp: 33};

   localparam bit DEF_H_POL = 1'b0;
   localparam bit DEF_V_POL = 1'b0;

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank;
   } vid_ctl_t;

   function automatic vid_ctl_t ctl_idle(input bit h_pol, input bit v_pol);
      return '{hs: ~h_pol, vs: ~v_pol, blank: 1'b1};
   endfunction

   function automatic logic sync_level(input logic in_pulse, input bit pol);
      return in_pulse ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active window and sync pulse decode.
module vga_axis_counter
   import vga_timing_gen_pkg::*;
#(
   parameter int unsigned ACTIVE = 800,
   parameter int unsigned FP     = 56,
   parameter int unsigned SYNC   = 120,
   parameter int unsigned BP     = 64,
   parameter bit          POL    = 1'b0,
   localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
   localparam int unsigned W     = $clog2(TOTAL)
) (
   input  logic         clk50,
   input  logic         rst,
   input  logic         tick,
   output logic [W-1:0] cnt,
   output logic         wrap,
   output logic         active,
   output logic         sync
);

   // One extra bit so a sync window ending exactly at TOTAL cannot overflow.
   localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
   localparam logic [W:0]   ACT_END  = (W+1)'(ACTIVE);
   localparam logic [W:0]   SYNC_BEG = (W+1)'(ACTIVE + FP);
   localparam logic [W:0]   SYNC_END = (W+1)'(ACTIVE + FP + SYNC);

   logic [W-1:0] r_cnt;
   logic [W:0]   w_cnt_x;

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (tick) begin
         r_cnt <= wrap ? '0 : r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_cnt_x = {1'b0, r_cnt};
      wrap    = tick && (r_cnt == LAST);
      active  = w_cnt_x < ACT_END;
      sync    = sync_level((w_cnt_x >= SYNC_BEG) && (w_cnt_x < SYNC_END), POL);
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V counters, registered coordinates and strobes,
// and a sync/blank delay line matching framebuffer read latency.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = VGA_800X600_72_H.active,
   parameter int unsigned H_FP       = VGA_800X600_72_H.fp,
   parameter int unsigned H_SYNC     = VGA_800X600_72_H.sync,
   parameter int unsigned H_BP       = VGA_800X600_72_H.bp,
   parameter int unsigned V_ACTIVE   = VGA_800X600_72_V.active,
   parameter int unsigned V_FP       = VGA_800X600_72_V.fp,
   parameter int unsigned V_SYNC     = VGA_800X600_72_V.sync,
   parameter int unsigned V_BP       = VGA_800X600_72_V.bp,
   parameter bit          H_POL      = DEF_H_POL,
   parameter bit          V_POL      = DEF_V_POL,
   parameter int unsigned PIPE_DELAY = 2,
   localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic          clk50,
   input  logic          rst,
   input  logic          en,
   output logic [HW-1:0] x_out,
   output logic [VW-1:0] y_out,
   output logic          active_out,
   output logic          newline_out,
   output logic          newframe_out,
   output logic          hsync_out,
   output logic          vsync_out,
   output logic          blank_out
);

   if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0 || PIPE_DELAY > 8)
   begin : g_bad_cfg
      $error("vga_timing_gen: invalid timing parameters");
   end

   localparam vid_ctl_t CTL_IDLE = ctl_idle(H_POL, V_POL);

   logic [HW-1:0] w_h_cnt;
   logic [VW-1:0] w_v_cnt;
   logic          w_h_wrap, w_h_active, w_h_sync;
   logic          w_v_wrap, w_v_active, w_v_sync;
   logic          w_active;
   vid_ctl_t      w_ctl_out;

   logic [HW-1:0] r_x;
   logic [VW-1:0] r_y;
   logic          r_active, r_newline, r_newframe;
   logic          r_fresh;
   vid_ctl_t      r_ctl;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (H_POL)
   ) u_h_axis (
      .clk50  (clk50),
      .rst    (rst),
      .tick   (en),
      .cnt    (w_h_cnt),
      .wrap   (w_h_wrap),
      .active (w_h_active),
      .sync   (w_h_sync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (V_POL)
   ) u_v_axis (
      .clk50  (clk50),
      .rst    (rst),
      .tick   (w_h_wrap),
      .cnt    (w_v_cnt),
      .wrap   (w_v_wrap),
      .active (w_v_active),
      .sync   (w_v_sync)
   );

   assign w_active = w_h_active && w_v_active;

   // r_fresh marks a counter position not yet presented, so a held position strobes once.
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_x        <= '0;
         r_y        <= '0;
         r_active   <= 1'b0;
         r_newline  <= 1'b0;
         r_newframe <= 1'b0;
         r_fresh    <= 1'b1;
         r_ctl      <= CTL_IDLE;
      end else begin
         r_x        <= w_h_cnt;
         r_y        <= w_v_cnt;
         r_active   <= w_active;
         r_newline  <= r_fresh && (w_h_cnt == '0);
         r_newframe <= r_fresh && (w_h_cnt == '0) && (w_v_cnt == VW'(V_ACTIVE));
         r_fresh    <= en;
         r_ctl      <= '{hs: w_h_sync, vs: w_v_sync, blank: ~w_active};
      end
   end

   if (PIPE_DELAY == 0) begin : g_direct
      assign w_ctl_out = r_ctl;
   end else begin : g_pipe
      vid_ctl_t r_pipe [PIPE_DELAY];

      always_ff @(posedge clk50 or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= CTL_IDLE;
         end else begin
            r_pipe[0] <= r_ctl;
            for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
         end
      end

      assign w_ctl_out = r_pipe[PIPE_DELAY-1];
   end

   a_v_wrap_with_h : assert property (@(posedge clk50) disable iff (rst) w_v_wrap |-> w_h_wrap);

   assign x_out        = r_x;
   assign y_out        = r_y;
   assign active_out   = r_active;
   assign newline_out  = r_newline;
   assign newframe_out = r_newframe;
   assign hsync_out    = w_ctl_out.hs;
   assign vsync_out    = w_ctl_out.vs;
   assign blank_out    = w_ctl_out.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: directed stimulus queues expected (cycle, probe, value) items; a negedge
// monitor pops and compares them. Default, small (PIPE_DELAY 0) and small (PIPE_DELAY 8) DUTs.
module tb_vga_timing_gen;

   typedef enum int {
      DX, DY, DACT, DNL, DNF, DHS, DVS, DBL, DHSLOW, DLINE,
      SX, SY, SACT, SNL, SNF, SHS, SVS, SBL, SFRAME, SVSHI,
      EX, EY, EHS, EVS, EBL
   } probe_e;

   typedef struct {
      int unsigned cyc;
      probe_e      id;
      int unsigned exp;
   } item_t;

   logic clk = 1'b0;
   logic rst_d, rst_s, en_d, en_s;
   int unsigned cyc = 0;
   int unsigned c0, c1, c_r;
   int n_checks = 0;
   int n_fail = 0;
   item_t sb_q [$];

   logic [10:0] d_x;
   logic [9:0]  d_y;
   logic        d_act, d_nl, d_nf, d_hs, d_vs, d_bl;
   logic [3:0]  s_x, e_x;
   logic [2:0]  s_y, e_y;
   logic        s_act, s_nl, s_nf, s_hs, s_vs, s_bl;
   logic        e_act, e_nl, e_nf, e_hs, e_vs, e_bl;

   int unsigned d_line_cnt = 0, d_line_last = 0, d_hs_run = 0, d_hs_last = 0;
   int unsigned s_frm_cnt = 0, s_frm_last = 0, s_vs_run = 0, s_vs_last = 0;
   logic d_hs_prev = 1'b1, s_vs_prev = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_timing_gen u_def (
      .clk50(clk), .rst(rst_d), .en(en_d), .x_out(d_x), .y_out(d_y), .active_out(d_act),
      .newline_out(d_nl), .newframe_out(d_nf), .hsync_out(d_hs), .vsync_out(d_vs),
      .blank_out(d_bl)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
      .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(0)
   ) u_s0 (
      .clk50(clk), .rst(rst_s), .en(en_s), .x_out(s_x), .y_out(s_y), .active_out(s_act),
      .newline_out(s_nl), .newframe_out(s_nf), .hsync_out(s_hs), .vsync_out(s_vs),
      .blank_out(s_bl)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
      .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(8)
   ) u_s8 (
      .clk50(clk), .rst(rst_s), .en(en_s), .x_out(e_x), .y_out(e_y), .active_out(e_act),
      .newline_out(e_nl), .newframe_out(e_nf), .hsync_out(e_hs), .vsync_out(e_vs),
      .blank_out(e_bl)
   );

   function automatic int unsigned actual(input probe_e p);
      case (p)
         DX:      return 32'(d_x);
         DY:      return 32'(d_y);
         DACT:    return 32'(d_act);
         DNL:     return 32'(d_nl);
         DNF:     return 32'(d_nf);
         DHS:     return 32'(d_hs);
         DVS:     return 32'(d_vs);
         DBL:     return 32'(d_bl);
         DHSLOW:  return d_hs_last;
         DLINE:   return d_line_last;
         SX:      return 32'(s_x);
         SY:      return 32'(s_y);
         SACT:    return 32'(s_act);
         SNL:     return 32'(s_nl);
         SNF:     return 32'(s_nf);
         SHS:     return 32'(s_hs);
         SVS:     return 32'(s_vs);
         SBL:     return 32'(s_bl);
         SFRAME:  return s_frm_last;
         SVSHI:   return s_vs_last;
         EX:      return 32'(e_x);
         EY:      return 32'(e_y);
         EHS:     return 32'(e_hs);
         EVS:     return 32'(e_vs);
         EBL:     return 32'(e_bl);
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Monitor: update run-length measurements, then check every item due this cycle.
   initial forever begin
      @(negedge clk);
      d_line_cnt++;
      if (d_nl) begin
         d_line_last = d_line_cnt;
         d_line_cnt  = 0;
      end
      if (!d_hs) d_hs_run++;
      else if (!d_hs_prev) begin
         d_hs_last = d_hs_run;
         d_hs_run  = 0;
      end
      d_hs_prev = d_hs;
      s_frm_cnt++;
      if (s_nf) begin
         s_frm_last = s_frm_cnt;
         s_frm_cnt  = 0;
      end
      if (s_vs) s_vs_run++;
      else if (s_vs_prev) begin
         s_vs_last = s_vs_run;
         s_vs_run  = 0;
      end
      s_vs_prev = s_vs;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc) begin
            int unsigned act;
            act = actual(sb_q[i].id);
            n_checks++;
            if (act != sb_q[i].exp) begin
               n_fail++;
               $display("FAIL %s cyc=%0d actual=%0d expected=%0d", sb_q[i].id.name(), cyc,
                        act, sb_q[i].exp);
            end
            sb_q.delete(i);
         end
      end
   end

   task automatic push(input int unsigned base, input int unsigned k, input probe_e p,
                       input int unsigned exp);
      item_t it;
      it.cyc = base + k;
      it.id  = p;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic goto_cyc(input int unsigned c);
      repeat (c - cyc) @(posedge clk);
      #1;
   endtask

   task automatic load_reset(input int unsigned b);
      push(b, 0, DX, 0);  push(b, 0, DY, 0);  push(b, 0, DACT, 0); push(b, 0, DNL, 0);
      push(b, 0, DNF, 0); push(b, 0, DHS, 1); push(b, 0, DVS, 1);  push(b, 0, DBL, 1);
      push(b, 0, SHS, 0); push(b, 0, SVS, 0); push(b, 0, SBL, 1);  push(b, 0, SX, 0);
      push(b, 0, EHS, 0); push(b, 0, EBL, 1);
   endtask

   task automatic load_main(input int unsigned b);
      // default 800x600 timing, PIPE_DELAY 2
      push(b, 1, DX, 0);     push(b, 1, DY, 0);     push(b, 1, DNL, 1);   push(b, 1, DACT, 1);
      push(b, 1, DBL, 1);    push(b, 2, DX, 1);     push(b, 2, DNL, 0);   push(b, 2, DBL, 1);
      push(b, 3, DBL, 0);    push(b, 800, DACT, 1); push(b, 801, DX, 800);
      push(b, 801, DACT, 0); push(b, 803, DBL, 1);  push(b, 857, DX, 856);
      push(b, 858, DHS, 1);  push(b, 859, DHS, 0);  push(b, 978, DHS, 0); push(b, 979, DHS, 1);
      push(b, 980, DHSLOW, 120);
      push(b, 1040, DX, 1039); push(b, 1040, DY, 0); push(b, 1041, DX, 0); push(b, 1041, DY, 1);
      push(b, 1041, DNL, 1);   push(b, 1041, DVS, 1); push(b, 1042, DLINE, 1040);
      push(b, 1541, DX, 500);  push(b, 1566, DX, 500); push(b, 1566, DNL, 0);
      push(b, 1591, DX, 500);  push(b, 1592, DX, 501);
      push(b, 2131, DX, 0);    push(b, 2131, DY, 2);  push(b, 2131, DNL, 1);
      push(b, 2132, DLINE, 1090);
      push(b, 2830, DX, 699);  push(b, 2830, DY, 2);  push(b, 2830, DBL, 0);
      push(b, 2831, DX, 0);    push(b, 2831, DY, 0);  push(b, 2831, DACT, 0);
      push(b, 2831, DBL, 1);   push(b, 2831, DHS, 1); push(b, 2831, DVS, 1); push(b, 2831, DNL, 0);
      // small 14x7 timing, PIPE_DELAY 0
      push(b, 1, SX, 0);    push(b, 1, SY, 0);    push(b, 1, SACT, 1);  push(b, 1, SNL, 1);
      push(b, 1, SBL, 0);   push(b, 2, SNL, 0);   push(b, 8, SX, 7);    push(b, 8, SACT, 1);
      push(b, 9, SX, 8);    push(b, 9, SACT, 0);  push(b, 9, SBL, 1);   push(b, 10, SHS, 0);
      push(b, 11, SX, 10);  push(b, 11, SHS, 1);  push(b, 12, SHS, 1);  push(b, 13, SHS, 0);
      push(b, 14, SX, 13);  push(b, 15, SX, 0);   push(b, 15, SY, 1);   push(b, 15, SNL, 1);
      push(b, 43, SY, 3);   push(b, 43, SACT, 1); push(b, 57, SY, 4);   push(b, 57, SACT, 0);
      push(b, 57, SNF, 1);  push(b, 58, SNF, 0);  push(b, 70, SVS, 0);  push(b, 71, SY, 5);
      push(b, 71, SVS, 1);  push(b, 84, SVS, 1);  push(b, 85, SVS, 0);  push(b, 86, SVSHI, 14);
      push(b, 98, SX, 13);  push(b, 98, SY, 6);   push(b, 99, SX, 0);   push(b, 99, SY, 0);
      push(b, 99, SNL, 1);  push(b, 99, SNF, 0);  push(b, 155, SNF, 1); push(b, 156, SFRAME, 98);
      // small timing, PIPE_DELAY 8: same x/y, sync/blank 8 clocks later
      push(b, 1, EX, 0);    push(b, 5, EX, 4);    push(b, 15, EY, 1);   push(b, 8, EBL, 1);
      push(b, 9, EBL, 0);   push(b, 16, EBL, 0);  push(b, 17, EBL, 1);  push(b, 18, EHS, 0);
      push(b, 19, EHS, 1);  push(b, 20, EHS, 1);  push(b, 21, EHS, 0);  push(b, 78, EVS, 0);
      push(b, 79, EVS, 1);  push(b, 92, EVS, 1);  push(b, 93, EVS, 0);
   endtask

   task automatic load_post(input int unsigned b);
      push(b, 1, DX, 0);  push(b, 1, DY, 0);  push(b, 1, DNL, 1);
      push(b, 2, DX, 1);  push(b, 2, DBL, 1); push(b, 3, DBL, 0);
   endtask

   initial begin
      rst_d = 1'b1;
      rst_s = 1'b1;
      en_d  = 1'b1;
      en_s  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (d_x !== 11'd0) begin
         n_fail++;
         $display("FAIL reset d_x=%0d expected=0", d_x);
      end
      n_checks++;
      if (d_bl !== 1'b1) begin
         n_fail++;
         $display("FAIL reset d_bl=%0b expected=1", d_bl);
      end
      n_checks++;
      if (s_hs !== 1'b0) begin
         n_fail++;
         $display("FAIL reset s_hs=%0b expected=0", s_hs);
      end
      n_checks++;
      if (e_bl !== 1'b1) begin
         n_fail++;
         $display("FAIL reset e_bl=%0b expected=1", e_bl);
      end
      c_r = cyc;
      load_reset(c_r);
      goto_cyc(c_r + 1);
      rst_d = 1'b0;
      rst_s = 1'b0;
      c0 = cyc;
      load_main(c0);
      goto_cyc(c0 + 1540);
      en_d = 1'b0;
      goto_cyc(c0 + 1590);
      en_d = 1'b1;
      goto_cyc(c0 + 2831);
      rst_d = 1'b1;
      goto_cyc(c0 + 2834);
      rst_d = 1'b0;
      c1 = cyc;
      load_post(c1);
      goto_cyc(c1 + 10);
      // Anything still queued was never compared.
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %0d scoreboard items never compared", sb_q.size());
      end
      foreach (sb_q[i]) begin
         $display("FAIL %s unchecked at cyc=%0d expected=%0d", sb_q[i].id.name(), sb_q[i].cyc,
                  sb_q[i].exp);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
